trigger_scaler_bank: RTL

Parametrised multi-channel successor to the single-channel trigger scaler. It takes NCH already-synchronised trigger bits and produces the following, all in one clock domain:
- per-channel power/mask gating;
- a programmable-length non-retriggerable one-shot output;
- stuck-on detection;
- saturating rate scalers latched on a period strobe and read out through a request/valid port.

It sits between the trigger input synchronisers and the higher-level trigger logic and register readout.

---
 rtl/trigger_scaler_pkg.sv | 12 +
 rtl/trigger_scaler_chan.sv | 79 +++++++
 rtl/trigger_scaler_bank.sv | 56 +++++
 3 files changed

// File: rtl/trigger_scaler_pkg.sv
// trigger_scaler_pkg: default widths and constant helpers shared by the trigger scaler bank.
package trigger_scaler_pkg;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_OS_W    = 4;
  localparam int DEF_STUCK_W = 10;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/trigger_scaler_chan.sv
// trigger_scaler_chan: one channel's edge detect, one-shot, stuck-on logic and live/latched scalers.
// Stuck detection is built only when TRIGGER_SCALER_BANK_STUCK_EN is defined.
module trigger_scaler_chan import trigger_scaler_pkg::*; #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int OS_W    = DEF_OS_W,
  parameter int STUCK_W = DEF_STUCK_W
) (
  input  logic               fclk_i,
  input  logic               rst_n_i,
  input  logic               trig_i,
  input  logic               power_i,
  input  logic               mask_i,
  input  logic [OS_W-1:0]    oneshot_len_i,
  input  logic [STUCK_W-1:0] stuck_limit_i,
  input  logic               period_i,
  output logic               trig_o,
  output logic               stuck_o,
  output logic [CNT_W-1:0]   latched_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  logic trig_d_q, trig_d_d, rise, active, sticky;
  logic [OS_W-1:0] os_q, os_d;
  logic [CNT_W-1:0] live_q, live_d, latched_q, latched_d;
  assign rise   = trig_i & ~trig_d_q & power_i;
  assign active = |os_q;
  assign trig_o = active & ~mask_i & ~stuck_o;
  assign latched_o = latched_q;
  always_comb begin
    trig_d_d  = power_i & trig_i;
    os_d      = !power_i ? '0 :
                (rise && !active) ? ((|oneshot_len_i) ? oneshot_len_i : OS_W'(1)) :
                active ? os_q - OS_W'(1) : '0;
    live_d    = !power_i ? '0 :
                period_i ? CNT_W'(rise) :
                (rise && live_q != CNT_MAX) ? live_q + CNT_W'(1) : live_q;
    latched_d = period_i ? (sticky ? '1 : live_q) : latched_q;
  end
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_d_q  <= 1'b0;
      os_q      <= '0;
      live_q    <= '0;
      latched_q <= '0;
    end else begin
      trig_d_q  <= trig_d_d;
      os_q      <= os_d;
      live_q    <= live_d;
      latched_q <= latched_d;
    end
  end
`ifdef TRIGGER_SCALER_BANK_STUCK_EN
  logic [STUCK_W-1:0] sc_q, sc_d;
  logic stuck_q, stuck_d, sticky_q, sticky_d;
  assign stuck_o = stuck_q & (|stuck_limit_i);
  assign sticky  = sticky_q;
  // stuck latches when the run length first hits the limit and holds while the input stays high
  always_comb begin
    sc_d     = (power_i && trig_i) ? sc_q + STUCK_W'(~&sc_q) : '0;
    stuck_d  = power_i && trig_i && (|stuck_limit_i) && (stuck_q || sc_d == stuck_limit_i);
    sticky_d = (period_i ? 1'b0 : sticky_q) | stuck_o;
  end
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sc_q     <= '0;
      stuck_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      stuck_q  <= stuck_d;
      sticky_q <= sticky_d;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^stuck_limit_i;
  assign stuck_o = 1'b0;
  assign sticky  = 1'b0;
`endif
endmodule

// File: rtl/trigger_scaler_bank.sv
// trigger_scaler_bank: NCH gated one-shot trigger channels with rate scalers and a request/valid readout.
// Stuck-on detection is built when TRIGGER_SCALER_BANK_STUCK_EN is defined.
module trigger_scaler_bank import trigger_scaler_pkg::*; #(
  parameter int NCH     = 16,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int OS_W    = DEF_OS_W,
  parameter int STUCK_W = DEF_STUCK_W
) (
  input  logic                    fclk_i,
  input  logic                    rst_n_i,
  input  logic [NCH-1:0]          trig_i,
  input  logic [NCH-1:0]          power_i,
  input  logic [NCH-1:0]          mask_i,
  input  logic [OS_W-1:0]         oneshot_len_i,
  input  logic [STUCK_W-1:0]      stuck_limit_i,
  input  logic                    period_i,
  input  logic                    rd_req_i,
  input  logic [sel_w(NCH)-1:0]   rd_sel_i,
  output logic [NCH-1:0]          trig_o,
  output logic [NCH-1:0]          stuck_o,
  output logic                    period_done_o,
  output logic                    rd_valid_o,
  output logic [CNT_W-1:0]        rd_data_o
);
  logic [CNT_W-1:0] lat [NCH];
  logic period_done_q, rd_valid_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_chan
      trigger_scaler_chan #(.CNT_W(CNT_W), .OS_W(OS_W), .STUCK_W(STUCK_W)) u_chan (
        .fclk_i(fclk_i), .rst_n_i(rst_n_i), .trig_i(trig_i[c]), .power_i(power_i[c]),
        .mask_i(mask_i[c]), .oneshot_len_i(oneshot_len_i), .stuck_limit_i(stuck_limit_i),
        .period_i(period_i), .trig_o(trig_o[c]), .stuck_o(stuck_o[c]), .latched_o(lat[c])
      );
    end
  endgenerate
  // latched values read here are the pre-period ones even when period_i coincides
  always_comb begin
    rd_data_d = rd_req_i ? ((int'(rd_sel_i) < NCH) ? lat[rd_sel_i] : '0) : rd_data_q;
  end
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_done_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      period_done_q <= period_i;
      rd_valid_q    <= rd_req_i;
      rd_data_q     <= rd_data_d;
    end
  end
  assign period_done_o = period_done_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
endmodule
